nn_perceptron_trainer: RTL
==========================

// Module: nn_perceptron_trainer
// PURPOSE
//  Training-side counterpart of the 2-input neuron: iterates a 2-input truth table through
//  a forward pass, computes error and back-applies the perceptron update to w0/w1/bias.
//  Sits beside the neuron/sigmoid datapath; its trained w0/w1/bias feed the forward network.
//  Start/busy/done handshake; stops on a clean epoch or after MAX_EPOCHS.
// PARAMETERS
//  W           8   signed two's-complement width of w0, w1, bias
//  LR          1   integer learning rate (1..2**(W-2)); update step = +/-LR
//  MAX_EPOCHS  16  epoch limit before giving up (>=1)
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       start training; accepted only in IDLE
//  target       in   4       target[i] = desired out for x0=i[0], x1=i[1]; latched at start
//  w0_init      in   W       signed initial w0; latched at start
//  w1_init      in   W       signed initial w1; latched at start
//  bias_init    in   W       signed initial bias; latched at start
//  busy         out  1       high in EVAL/UPDATE/CHECK
//  done         out  1       one-cycle pulse when training ends
//  converged    out  1       1 = last epoch had zero errors; held until next start
//  w0,w1,bias   out  W each  current signed weights (live while busy, held after done)
//  epoch_count  out  $clog2(MAX_EPOCHS+1)  epochs completed, incl. final clean one
//  sat_hit      out  1       sticky: any update clamped (0 when macro absent)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=done=converged=sat_hit=0; w0=w1=bias=0; epoch_count=0.
//  - rst beats start in the same cycle; rst mid-training aborts to IDLE, no done pulse.
//  - FSM IDLE -> EVAL -> UPDATE -> (EVAL | CHECK) -> (EVAL | DONE) -> IDLE.
//  - IDLE: on start load inits + target, idx=0, err_seen=0, epoch_count=0, converged=0,
//    sat_hit=0 -> EVAL. start while not IDLE is ignored.
//  - EVAL (1 cyc): x0=idx[0], x1=idx[1]; sum = w0*x0 + w1*x1 + bias, signed, W+2 bits,
//    sign-extended, never overflows; y = (sum > 0); err = target[idx] - y in {-1,0,+1}; registered.
//  - UPDATE (1 cyc): if err!=0: w0 += LR*err*x0, w1 += LR*err*x1, bias += LR*err;
//    err_seen=1. If idx==3 -> CHECK, else idx++ -> EVAL.
//  - CHECK (1 cyc): epoch_count++. If !err_seen -> DONE, converged=1.
//    Else if new epoch_count==MAX_EPOCHS -> DONE, converged=0.
//    Else idx=0, err_seen=0 -> EVAL.
//  - DONE (1 cyc): done=1, busy=0 -> IDLE. Epoch = 9 cycles; done is high
//    1+9*E cycles after the start cycle (E = final epoch_count).
//  - Weight arithmetic: W-bit two's-complement wrap unless NN_TRAIN_SATURATE_EN.
// CONFIGURATION
//  NN_TRAIN_SATURATE_EN defined: each updated weight clamped to [-2**(W-1), 2**(W-1)-1];
//    any clamp sets sat_hit (sticky until next start/rst).
//  NN_TRAIN_SATURATE_EN undefined: weights wrap modulo 2**W; sat_hit tied 0. Port list identical.
// TESTING
//  1 AND: target=4'b1000, inits 0/0/0 -> done 55 cyc after start, converged=1,
//    epoch_count=6, w0=1, w1=2, bias=-2.
//  2 XOR: target=4'b0110, inits 0 -> done 1+9*16=145 cyc after start, converged=0, epoch_count=16.
//  3 Pretrained AND: inits 20/20/-30, target=4'b1000 -> converged after 1 epoch (done at
//    cycle 10), weights unchanged.
//  4 Saturation: target=4'b1111, w0_init=127, w1_init=0, bias_init=-128: with macro w0 stays 127
//    and sat_hit=1 after sample 1; without macro w0 wraps to -128, sat_hit=0.
//  5 Reset mid-run: assert rst in epoch 2 of test 1 -> next cycle IDLE, all outputs at reset
//    values, no done; restart reproduces test 1 exactly.
//  6 Protocol: start held high throughout test 1 -> ignored while busy, one done pulse,
//    retrains from IDLE on next cycle.

Source files
------------

// File: rtl/nn_perceptron_trainer_if.sv
// Bus between the perceptron trainer and its controller.
// Controller (master) drives start, target and the initial weights.
// Trainer (slave) returns busy/done/converged, the live weights,
// the completed-epoch count and the sticky saturation flag.
interface nn_perceptron_trainer_if #(
    parameter int unsigned W          = 8,
    parameter int unsigned MAX_EPOCHS = 16
);
    localparam int unsigned EW = $clog2(MAX_EPOCHS + 1);

    logic                 start;
    logic [3:0]           target;
    logic signed [W-1:0]  w0_init;
    logic signed [W-1:0]  w1_init;
    logic signed [W-1:0]  bias_init;
    logic                 busy;
    logic                 done;
    logic                 converged;
    logic signed [W-1:0]  w0;
    logic signed [W-1:0]  w1;
    logic signed [W-1:0]  bias;
    logic [EW-1:0]        epoch_count;
    logic                 sat_hit;

    modport master (
        output start, target, w0_init, w1_init, bias_init,
        input  busy, done, converged, w0, w1, bias, epoch_count, sat_hit
    );

    modport slave (
        input  start, target, w0_init, w1_init, bias_init,
        output busy, done, converged, w0, w1, bias, epoch_count, sat_hit
    );
endinterface

// File: rtl/nn_perceptron_trainer.sv
// Perceptron trainer for the 2-input neuron.
// Walks the 4-row truth table once per epoch: EVAL computes the forward
// pass and the error, UPDATE applies +/-LR to w0/w1/bias, CHECK closes the
// epoch. Training stops on an error-free epoch or after MAX_EPOCHS.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   bus   - nn_perceptron_trainer_if.slave (start/target/inits in,
//           busy/done/converged/weights/epoch_count/sat_hit out)
// Optional feature: define NN_TRAIN_SATURATE_EN to clamp weight updates to
// the signed W-bit range and report clamps on sat_hit; otherwise weights
// wrap modulo 2**W and sat_hit stays 0.
module nn_perceptron_trainer #(
    parameter int unsigned W          = 8,
    parameter int unsigned LR         = 1,
    parameter int unsigned MAX_EPOCHS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    nn_perceptron_trainer_if.slave  bus
);
    localparam int unsigned EW = $clog2(MAX_EPOCHS + 1);
    localparam int unsigned SW = W + 2;
    localparam logic signed [SW-1:0] LR_S   = SW'(LR);
    localparam logic signed [SW-1:0] ZERO_S = SW'(0);
    localparam logic [EW-1:0]        EPOCH_LIMIT = EW'(MAX_EPOCHS);
`ifdef NN_TRAIN_SATURATE_EN
    localparam logic signed [SW-1:0] W_MAX = SW'((1 << (W - 1)) - 1);
    localparam logic signed [SW-1:0] W_MIN = ~W_MAX;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [3:0]           r_target,   w_target_nxt;
    logic signed [W-1:0]  r_w0,       w_w0_nxt;
    logic signed [W-1:0]  r_w1,       w_w1_nxt;
    logic signed [W-1:0]  r_bias,     w_bias_nxt;
    logic [1:0]           r_idx,      w_idx_nxt;
    logic                 r_err_seen, w_err_seen_nxt;
    logic signed [1:0]    r_err,      w_err_nxt;
    logic [EW-1:0]        r_epoch,    w_epoch_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_conv,     w_conv_nxt;
    logic                 r_sat,      w_sat_nxt;

    logic signed [SW-1:0] w_sum;
    logic                 w_y;
    logic                 w_tgt;
    logic signed [1:0]    w_err_eval;
    logic signed [SW-1:0] w_step;
    logic [W:0]           w_upd_w0;
    logic [W:0]           w_upd_w1;
    logic [W:0]           w_upd_bias;

    // Add step to a weight when enabled; returns {clamped, new_weight}.
    function automatic logic [W:0] f_update(
        input logic signed [W-1:0]  i_w,
        input logic                 i_en,
        input logic signed [SW-1:0] i_step
    );
        logic signed [SW-1:0] v_sum;
        logic                 v_clip;
        v_sum  = $signed({{2{i_w[W-1]}}, i_w}) + (i_en ? i_step : ZERO_S);
        v_clip = 1'b0;
`ifdef NN_TRAIN_SATURATE_EN
        if (v_sum > W_MAX) begin
            v_sum  = W_MAX;
            v_clip = 1'b1;
        end else if (v_sum < W_MIN) begin
            v_sum  = W_MIN;
            v_clip = 1'b1;
        end
`endif
        return {v_clip, v_sum[W-1:0]};
    endfunction

    // Forward pass: x0/x1 come straight from the row index; sum is wide enough never to overflow.
    always_comb begin
        w_sum = $signed({{2{r_bias[W-1]}}, r_bias});
        if (r_idx[0]) begin
            w_sum = w_sum + $signed({{2{r_w0[W-1]}}, r_w0});
        end
        if (r_idx[1]) begin
            w_sum = w_sum + $signed({{2{r_w1[W-1]}}, r_w1});
        end
        w_y   = !w_sum[SW-1] && (w_sum != ZERO_S);
        w_tgt = r_target[r_idx];
        if (w_tgt && !w_y) begin
            w_err_eval = 2'sb01;
        end else if (!w_tgt && w_y) begin
            w_err_eval = 2'sb11;
        end else begin
            w_err_eval = 2'sb00;
        end
    end

    // Perceptron step: +LR for err=+1, -LR for err=-1; bias input is always 1.
    assign w_step     = r_err[1] ? -LR_S : LR_S;
    assign w_upd_w0   = f_update(r_w0,   r_idx[0], w_step);
    assign w_upd_w1   = f_update(r_w1,   r_idx[1], w_step);
    assign w_upd_bias = f_update(r_bias, 1'b1,     w_step);

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_w0_nxt       = r_w0;
        w_w1_nxt       = r_w1;
        w_bias_nxt     = r_bias;
        w_idx_nxt      = r_idx;
        w_err_seen_nxt = r_err_seen;
        w_err_nxt      = r_err;
        w_epoch_nxt    = r_epoch;
        w_conv_nxt     = r_conv;
        w_sat_nxt      = r_sat;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_target_nxt   = bus.target;
                    w_w0_nxt       = bus.w0_init;
                    w_w1_nxt       = bus.w1_init;
                    w_bias_nxt     = bus.bias_init;
                    w_idx_nxt      = 2'd0;
                    w_err_seen_nxt = 1'b0;
                    w_epoch_nxt    = '0;
                    w_conv_nxt     = 1'b0;
                    w_sat_nxt      = 1'b0;
                    w_state_nxt    = S_EVAL;
                end
            end
            S_EVAL: begin
                w_err_nxt   = w_err_eval;
                w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                if (r_err != 2'sb00) begin
                    w_w0_nxt       = $signed(w_upd_w0[W-1:0]);
                    w_w1_nxt       = $signed(w_upd_w1[W-1:0]);
                    w_bias_nxt     = $signed(w_upd_bias[W-1:0]);
                    w_err_seen_nxt = 1'b1;
                    w_sat_nxt      = r_sat | w_upd_w0[W] | w_upd_w1[W] | w_upd_bias[W];
                end
                if (r_idx == 2'd3) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = S_EVAL;
                end
            end
            S_CHECK: begin
                w_epoch_nxt = r_epoch + EW'(1);
                if (!r_err_seen) begin
                    w_conv_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_epoch_nxt == EPOCH_LIMIT) begin
                    w_conv_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt      = 2'd0;
                    w_err_seen_nxt = 1'b0;
                    w_state_nxt    = S_EVAL;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with it.
        w_busy_nxt = (w_state_nxt == S_EVAL) || (w_state_nxt == S_UPDATE) ||
                     (w_state_nxt == S_CHECK);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_target   <= 4'd0;
            r_w0       <= '0;
            r_w1       <= '0;
            r_bias     <= '0;
            r_idx      <= 2'd0;
            r_err_seen <= 1'b0;
            r_err      <= 2'sb00;
            r_epoch    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conv     <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_w0       <= w_w0_nxt;
            r_w1       <= w_w1_nxt;
            r_bias     <= w_bias_nxt;
            r_idx      <= w_idx_nxt;
            r_err_seen <= w_err_seen_nxt;
            r_err      <= w_err_nxt;
            r_epoch    <= w_epoch_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_conv     <= w_conv_nxt;
            r_sat      <= w_sat_nxt;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.converged   = r_conv;
    assign bus.w0          = r_w0;
    assign bus.w1          = r_w1;
    assign bus.bias        = r_bias;
    assign bus.epoch_count = r_epoch;
    assign bus.sat_hit     = r_sat;
endmodule
